// File: rtl/controller.sv
// Multicycle datapath control FSM: byte-wide fetch, decode and per-opcode execute sequencing.
// Optional macro CONTROLLER_ADDI_EN enables the ADDI path (MEMADR -> ADDIWR).
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] pcsource,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [3:0] irwrite,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b100100;
  localparam logic [OP_W-1:0] OP_J     = 6'b100010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    FETCH1  = 4'b0001,
    FETCH2  = 4'b0010,
    FETCH3  = 4'b0011,
    FETCH4  = 4'b0100,
    DECODE  = 4'b0101,
    MEMADR  = 4'b0110,
    LBRD    = 4'b0111,
    LBWR    = 4'b1000,
    SBWR    = 4'b1001,
    RTYPEEX = 4'b1010,
    RTYPEWR = 4'b1011,
    BEQEX   = 4'b1100,
    JEX     = 4'b1101,
    ADDIWR  = 4'b1110
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   pcwrite;
  logic   branch;

  // State register; reset is purely synchronous
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH1;
    else     state_q <= state_d;
  end

  // Next-state logic; op is only consulted in DECODE and MEMADR
  always_comb begin
    state_d = FETCH1;
    case (state_q)
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = FETCH3;
      FETCH3:  state_d = FETCH4;
      FETCH4:  state_d = DECODE;
      DECODE: begin
        if (op == OP_LB || op == OP_SB)  state_d = MEMADR;
`ifdef CONTROLLER_ADDI_EN
        else if (op == OP_ADDI)          state_d = MEMADR;
`endif
        else if (op == OP_RTYPE)         state_d = RTYPEEX;
        else if (op == OP_BEQ)           state_d = BEQEX;
        else if (op == OP_J)             state_d = JEX;
        else                             state_d = FETCH1;
      end
      MEMADR: begin
        if (op == OP_LB)                 state_d = LBRD;
        else if (op == OP_SB)            state_d = SBWR;
`ifdef CONTROLLER_ADDI_EN
        else if (op == OP_ADDI)          state_d = ADDIWR;
`endif
        else                             state_d = FETCH1;
      end
      LBRD:    state_d = LBWR;
      RTYPEEX: state_d = RTYPEWR;
      default: state_d = FETCH1;
    endcase
  end

  // Moore output decode; only pcen also looks at zero
  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcsource = 2'b00;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    irwrite  = 4'b0000;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_q)
      FETCH1: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0001;
      end
      FETCH2: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0010;
      end
      FETCH3: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b0100;
      end
      FETCH4: begin
        memread = 1'b1; alusrcb = 2'b01; pcwrite = 1'b1; irwrite = 4'b1000;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1; alusrcb = 2'b10;
      end
      LBRD: begin
        memread = 1'b1; iord = 1'b1;
      end
      LBWR: begin
        regwrite = 1'b1; memtoreg = 1'b1;
      end
      SBWR: begin
        memwrite = 1'b1; iord = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1; aluop = 2'b10;
      end
      RTYPEWR: begin
        regwrite = 1'b1; regdst = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1; aluop = 2'b01; branch = 1'b1; pcsource = 2'b01;
      end
      JEX: begin
        pcwrite = 1'b1; pcsource = 2'b10;
      end
`ifdef CONTROLLER_ADDI_EN
      ADDIWR:  regwrite = 1'b1;
`endif
      default: ;
    endcase
    pcen = pcwrite | (branch & zero);
  end

  assign state = state_q;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expected state/output vectors are queued per cycle and
// popped at each falling edge. Define CONTROLLER_ADDI_EN to match an ADDI-enabled build.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
  logic [1:0] pcsource, alusrcb, aluop;
  logic [3:0] irwrite, state;

  always #5 clk = ~clk;

  controller dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .memtoreg(memtoreg),
    .iord(iord), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
    .pcsource(pcsource), .alusrcb(alusrcb), .aluop(aluop), .irwrite(irwrite),
    .state(state)
  );

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b100100;
  localparam logic [5:0] OP_J     = 6'b100010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // {memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst, pcsource, alusrcb, aluop, irwrite}
  logic [17:0] obs;
  assign obs = {memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst,
                pcsource, alusrcb, aluop, irwrite};

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] outs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference output table indexed by state code
  function automatic logic [17:0] exp_outs(input logic [3:0] s, input logic z);
    logic mr, mw, asa, mtr, io, pe, rw, rd;
    logic [1:0] ps, asb, ao;
    logic [3:0] ir;
    mr = 0; mw = 0; asa = 0; mtr = 0; io = 0; pe = 0; rw = 0; rd = 0;
    ps = 2'b00; asb = 2'b00; ao = 2'b00; ir = 4'b0000;
    case (s)
      4'b0001: begin mr = 1; asb = 2'b01; pe = 1; ir = 4'b0001; end
      4'b0010: begin mr = 1; asb = 2'b01; pe = 1; ir = 4'b0010; end
      4'b0011: begin mr = 1; asb = 2'b01; pe = 1; ir = 4'b0100; end
      4'b0100: begin mr = 1; asb = 2'b01; pe = 1; ir = 4'b1000; end
      4'b0101: asb = 2'b11;
      4'b0110: begin asa = 1; asb = 2'b10; end
      4'b0111: begin mr = 1; io = 1; end
      4'b1000: begin rw = 1; mtr = 1; end
      4'b1001: begin mw = 1; io = 1; end
      4'b1010: begin asa = 1; ao = 2'b10; end
      4'b1011: begin rw = 1; rd = 1; end
      4'b1100: begin asa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      4'b1101: begin pe = 1; ps = 2'b10; end
`ifdef CONTROLLER_ADDI_EN
      4'b1110: rw = 1;
`endif
      default: ;
    endcase
    return {mr, mw, asa, mtr, io, pe, rw, rd, ps, asb, ao, ir};
  endfunction

  function automatic void sb_push(input logic [3:0] s, input logic z);
    exp_t e;
    e.st   = s;
    e.outs = exp_outs(s, z);
    sb.push_back(e);
  endfunction

  // FETCH1..FETCH4 then DECODE
  function automatic void push_fetch(input logic z);
    for (int s = 1; s <= 5; s++) sb_push(4'(s), z);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k <= 8; k++) begin
      do_reset();
      op = OP_LB;
      zero = 1'b0;
      repeat (k) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_push(4'b0001, zero);
      e = sb.pop_front();
      checks++;
      if ({state, obs} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL reset after %0d cycles: got state=%b outs=%b want state=%b outs=%b",
                 k, state, obs, e.st, e.outs);
      end
    end
  endtask

  task automatic test_lb();
    exp_t e;
    do_reset();
    op = OP_LB;
    zero = 1'b0;
    push_fetch(zero);
    sb_push(4'b0110, zero); sb_push(4'b0111, zero); sb_push(4'b1000, zero); sb_push(4'b0001, zero);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({state, obs} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL lb path: got state=%b outs=%b want state=%b outs=%b", state, obs, e.st, e.outs);
      end
      if (sb.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_sb_rtype();
    exp_t e;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      op = (t == 0) ? OP_SB : OP_RTYPE;
      zero = 1'b1;
      push_fetch(zero);
      if (t == 0) begin sb_push(4'b0110, zero); sb_push(4'b1001, zero); end
      else        begin sb_push(4'b1010, zero); sb_push(4'b1011, zero); end
      sb_push(4'b0001, zero);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({state, obs} !== {e.st, e.outs}) begin
          errors++;
          $display("FAIL %s path: got state=%b outs=%b want state=%b outs=%b",
                   (t == 0) ? "sb" : "rtype", state, obs, e.st, e.outs);
        end
        if (sb.size() > 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_beq();
    exp_t e;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      op = OP_BEQ;
      zero = (t == 0);
      push_fetch(zero);
      sb_push(4'b1100, zero); sb_push(4'b0001, zero);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({state, obs} !== {e.st, e.outs}) begin
          errors++;
          $display("FAIL beq zero=%0d: got state=%b outs=%b want state=%b outs=%b",
                   zero, state, obs, e.st, e.outs);
        end
        // pcen must track zero within BEQEX without waiting for an edge
        if (e.st == 4'b1100 && t == 0) begin
          zero = 1'b0;
          #1;
          checks++;
          if (pcen !== 1'b0) begin
            errors++;
            $display("FAIL beq pcen follows zero: got %b want 0", pcen);
          end
          zero = 1'b1;
          #1;
        end
        if (sb.size() > 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_j_and_bad();
    exp_t e;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      op = (t == 0) ? OP_J : OP_BAD;
      zero = 1'b0;
      push_fetch(zero);
      if (t == 0) sb_push(4'b1101, zero);
      sb_push(4'b0001, zero);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({state, obs} !== {e.st, e.outs}) begin
          errors++;
          $display("FAIL %s path: got state=%b outs=%b want state=%b outs=%b",
                   (t == 0) ? "j" : "bad op", state, obs, e.st, e.outs);
        end
        if (sb.size() > 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_addi();
    exp_t e;
    do_reset();
    op = OP_ADDI;
    zero = 1'b0;
    push_fetch(zero);
`ifdef CONTROLLER_ADDI_EN
    sb_push(4'b0110, zero); sb_push(4'b1110, zero);
`endif
    sb_push(4'b0001, zero);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({state, obs} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL addi path: got state=%b outs=%b want state=%b outs=%b", state, obs, e.st, e.outs);
      end
      if (sb.size() > 0) @(negedge clk);
    end
  endtask

  // op only matters on the edges leaving DECODE and MEMADR
  task automatic test_op_ignored();
    exp_t e;
    do_reset();
    op = OP_BAD;
    zero = 1'b0;
    push_fetch(zero);
    sb_push(4'b0110, zero); sb_push(4'b1001, zero); sb_push(4'b0001, zero);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({state, obs} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL op ignored: got state=%b outs=%b want state=%b outs=%b op=%b",
                 state, obs, e.st, e.outs, op);
      end
      if (e.st == 4'b0101 || e.st == 4'b0110) op = OP_SB;
      else op = (e.st[0]) ? OP_LB : OP_J;
      if (sb.size() > 0) @(negedge clk);
    end
  endtask

  // J then LB then BEQ with no reset in between
  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    op = OP_J;
    zero = 1'b0;
    push_fetch(zero); sb_push(4'b1101, zero);
    push_fetch(zero); sb_push(4'b0110, zero); sb_push(4'b0111, zero); sb_push(4'b1000, zero);
    push_fetch(zero); sb_push(4'b1100, zero); sb_push(4'b0001, zero);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({state, obs} !== {e.st, e.outs}) begin
        errors++;
        $display("FAIL back to back: got state=%b outs=%b want state=%b outs=%b", state, obs, e.st, e.outs);
      end
      if (e.st == 4'b1101) op = OP_LB;
      if (e.st == 4'b1000) op = OP_BEQ;
      if (sb.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    rst  = 1'b1;
    op   = 6'b000000;
    zero = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_lb();
    test_sb_rtype();
    test_beq();
    test_j_and_bad();
    test_addi();
    test_op_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL be named controller, with one clock clk and a synchronous, active-high reset rst, sampled on the rising edge of clk.
REQ-002 Ports (name, direction, width, meaning), clock and reset first, SHALL be:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- op, in, 6: instruction opcode.
- zero, in, 1: ALU zero flag.
- memread, out, 1: memory read.
- memwrite, out, 1: memory write.
- alusrca, out, 1: ALU A select (0=PC, 1=reg A).
- memtoreg, out, 1: writeback select (1=memory data).
- iord, out, 1: address select (0=PC, 1=ALUOut).
- pcen, out, 1: PC load enable.
- regwrite, out, 1: register file write.
- regdst, out, 1: destination select (1=rd).
- pcsource, out, 2: next-PC select (00=ALU, 01=ALUOut, 10=jump target).
- alusrcb, out, 2: ALU B select (00=reg B, 01=const 1, 10=imm, 11=imm shifted).
- aluop, out, 2: 00=add, 01=sub, 10=funct.
- irwrite, out, 4: one-hot instruction byte enables.
- state, out, 4: current state code.

Function
REQ-003 The block SHALL be a Moore FSM; every output except pcen SHALL depend only on state; pcen = pcwrite | (branch & zero), where pcwrite and branch are internal.
REQ-004 State codes SHALL be:
- FETCH1 = 0001, FETCH2 = 0010, FETCH3 = 0011, FETCH4 = 0100
- DECODE = 0101, MEMADR = 0110, LBRD = 0111, LBWR = 1000
- SBWR = 1001, RTYPEEX = 1010, RTYPEWR = 1011, BEQEX = 1100
- JEX = 1101, ADDIWR = 1110
REQ-005 Opcodes SHALL be LB = 100000, SB = 101000, RTYPE = 000000, BEQ = 100100, J = 100010, ADDI = 001000.
REQ-006 Transitions SHALL be:
- FETCH1 -> FETCH2 -> FETCH3 -> FETCH4 -> DECODE.
- DECODE on LB, SB or ADDI -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; J -> JEX; any other opcode -> FETCH1.
- MEMADR on LB -> LBRD; SB -> SBWR; ADDI -> ADDIWR; other -> FETCH1.
- LBRD -> LBWR; RTYPEEX -> RTYPEWR.
- LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR -> FETCH1.
- Unused codes 0000 and 1111 -> FETCH1.
REQ-007 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.
REQ-008 Output defaults SHALL be 0 in every state; only the asserted values listed below differ:
- FETCHn (n = 1..4): memread=1, alusrcb=01, pcwrite=1, irwrite=1<<(n-1).
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- LBRD: memread=1, iord=1.
- LBWR: regwrite=1, memtoreg=1.
- SBWR: memwrite=1, iord=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWR: regwrite=1, regdst=1.
- BEQEX: alusrca=1, aluop=01, branch=1, pcsource=01.
- JEX: pcwrite=1, pcsource=10.
- ADDIWR: regwrite=1.
REQ-009 In BEQEX, pcen SHALL follow zero combinationally; in all other non-fetch, non-JEX states, pcen SHALL be 0.
REQ-010 Instruction latency from FETCH1 back to FETCH1 SHALL be: LB 8 cycles; SB, RTYPE, ADDI 7 cycles; BEQ, J 6 cycles.

Reset
REQ-011 When rst = 1 at a rising edge of clk, the next state SHALL be FETCH1, regardless of the current state (including mid-instruction).
REQ-012 While in FETCH1 after reset, the outputs SHALL be exactly the FETCH1 values in REQ-008 (pcen=1); the state register SHALL have no asynchronous path.

Configuration
REQ-013 With macro CONTROLLER_ADDI_EN defined, ADDI SHALL follow REQ-006; without it, ADDI SHALL be treated as an unknown opcode (DECODE -> FETCH1), and ADDIWR SHALL be unreachable, with code 1110 -> FETCH1.

Verification
REQ-014 The bench SHALL cover the following scenarios:
- rst = 1 for one edge in any state -> state = 0001, memread = 1, irwrite = 0001, pcen = 1.
- op = LB held -> states 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000, 0001; LBWR: regwrite = 1, memtoreg = 1.
- op = SB -> path ... 0101, 0110, 1001, 0001; SBWR: memwrite = 1, iord = 1.
- op = BEQ: zero = 1 -> BEQEX pcen = 1, pcsource = 01; zero = 0 -> pcen = 0.
- op = J -> 0101, 1101; pcen = 1, pcsource = 10. op = 111111 -> 0101, 0001.
- op = ADDI with macro -> 0110, 1110 (regwrite = 1, regdst = 0); without macro -> 0101, 0001.
